// File: rtl/store_buffer_if.sv
// CPU-side and RAM-side signal bundle for the store buffer.
// Handshake: a store is taken at the rising edge when ram_write_enable=1 and stall_request=0; while stall_request=1 the CPU holds its request unchanged.
interface store_buffer_if;
  logic        ram_write_enable;
  logic [31:0] ram_write_address;
  logic [3:0]  ram_write_select;
  logic [31:0] ram_write_data;
  logic        ram_read_enable;
  logic [31:0] ram_read_address;
  logic [31:0] ram_read_data;
  logic        stall_request;
  logic        mem_write_enable;
  logic [31:0] mem_write_address;
  logic [3:0]  mem_write_select;
  logic [31:0] mem_write_data;
  logic        mem_read_enable;
  logic [31:0] mem_read_address;
  logic [31:0] mem_read_data;

  // master: the CPU plus RAM environment around the buffer
  modport master (
    output ram_write_enable, ram_write_address, ram_write_select, ram_write_data,
    output ram_read_enable, ram_read_address, mem_read_data,
    input  ram_read_data, stall_request,
    input  mem_write_enable, mem_write_address, mem_write_select, mem_write_data,
    input  mem_read_enable, mem_read_address
  );

  modport slave (
    input  ram_write_enable, ram_write_address, ram_write_select, ram_write_data,
    input  ram_read_enable, ram_read_address, mem_read_data,
    output ram_read_data, stall_request,
    output mem_write_enable, mem_write_address, mem_write_select, mem_write_data,
    output mem_read_enable, mem_read_address
  );
endinterface

// File: rtl/store_buffer.sv
// Circular store buffer between CPU and RAM; stores drain whenever the RAM port is free of reads.
// Optional STORE_BUFFER_FORWARD_EN: read hits are merged per byte lane from buffered stores instead of stalling.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  store_buffer_if.slave          sif,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [29:0]   addr_q [DEPTH];
  logic [3:0]    sel_q  [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count_q;

  logic          hit;
  logic          hit_stall;
  logic          full;
  logic          drain;
  logic          stall;
  logic          enq;
  logic [31:0]   rd_data;
  logic [PW-1:0] idx;
  logic          unused_bits;

  assign count       = count_q;
  assign unused_bits = ^{sif.ram_write_address[1:0], sif.ram_read_address[1:0]};

  // Walk oldest to newest so later matches overwrite earlier lanes.
  always_comb begin
    hit     = 1'b0;
    rd_data = sif.mem_read_data;
    idx     = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (((PW+1)'(k) < count_q) && (addr_q[idx] == sif.ram_read_address[31:2])) begin
        hit = 1'b1;
`ifdef STORE_BUFFER_FORWARD_EN
        for (int b = 0; b < 4; b++) begin
          if (sel_q[idx][b]) rd_data[8*b +: 8] = data_q[idx][8*b +: 8];
        end
`endif
      end
    end
  end

`ifdef STORE_BUFFER_FORWARD_EN
  assign hit_stall = 1'b0;
`else
  assign hit_stall = sif.ram_read_enable && hit;
`endif

  assign full  = (count_q == (PW+1)'(DEPTH));
  // A stalled read hit frees the RAM port, so the hit entries can drain out.
  assign drain = !reset && (count_q != '0) && (!sif.ram_read_enable || hit_stall);
  assign stall = !reset && (hit_stall || (sif.ram_write_enable && full && !drain));
  assign enq   = !reset && sif.ram_write_enable && !stall;

  always_comb begin
    sif.stall_request     = stall;
    sif.ram_read_data     = reset ? '0 : rd_data;
    sif.mem_read_enable   = !reset && sif.ram_read_enable && !hit_stall;
    sif.mem_read_address  = (!reset && sif.ram_read_enable && !hit_stall) ? sif.ram_read_address : '0;
    sif.mem_write_enable  = drain;
    sif.mem_write_address = drain ? {addr_q[head], 2'b00} : '0;
    sif.mem_write_select  = drain ? sel_q[head] : '0;
    sif.mem_write_data    = drain ? data_q[head] : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (enq)   tail <= tail + 1'b1;
      if (drain) head <= head + 1'b1;
      count_q <= count_q + (PW+1)'(enq) - (PW+1)'(drain);
    end
  end

  always_ff @(posedge clock) begin
    if (enq) begin
      addr_q[tail] <= sif.ram_write_address[31:2];
      sel_q[tail]  <= sif.ram_write_select;
      data_q[tail] <= sif.ram_write_data;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: RAM model, architectural memory reference and FIFO scoreboard of pending stores.
module tb_store_buffer;
  localparam int DEPTH = 4;
`ifdef STORE_BUFFER_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic [$clog2(DEPTH):0] count;
  store_buffer_if sif();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clock(clock),
    .reset(reset),
    .sif  (sif),
    .count(count)
  );

  always #5 clock = ~clock;

  logic [31:0] ram    [1024];
  logic [31:0] golden [1024];
  logic [67:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int mem_writes = 0;

  assign sif.mem_read_data = ram[sif.mem_read_address[11:2]];

  always @(posedge clock) begin
    if (sif.mem_write_enable === 1'b1) begin
      mem_writes++;
      for (int b = 0; b < 4; b++)
        if (sif.mem_write_select[b]) ram[sif.mem_write_address[11:2]][8*b +: 8] = sif.mem_write_data[8*b +: 8];
    end
  end

  // Scoreboard: pending stores in program order, architectural memory for reads.
  always @(negedge clock) begin
    logic hit, hit_stall, drain_exp, stall_exp;
    logic [67:0] e;
    int n;
    if (reset) begin
      checks++;
      if (sif.mem_write_enable !== 1'b0 || sif.mem_read_enable !== 1'b0 || sif.stall_request !== 1'b0) begin
        errors++;
        $display("FAIL reset_enables: mem_we=%b mem_re=%b stall=%b, required 0", sif.mem_write_enable, sif.mem_read_enable, sif.stall_request);
      end
      exp_q.delete();
      golden = ram;
    end else begin
      hit = 1'b0;
      foreach (exp_q[i]) if (exp_q[i][67:38] == sif.ram_read_address[31:2]) hit = 1'b1;
      n = exp_q.size();
      hit_stall = !FWD && sif.ram_read_enable && hit;
      drain_exp = (n > 0) && (!sif.ram_read_enable || hit_stall);
      stall_exp = hit_stall || (sif.ram_write_enable && (n == DEPTH) && !drain_exp);

      checks++;
      if (sif.stall_request !== stall_exp) begin
        errors++;
        $display("FAIL stall @%0t: got %b, required %b", $time, sif.stall_request, stall_exp);
      end
      checks++;
      if (int'(count) != n) begin
        errors++;
        $display("FAIL count @%0t: got %0d, required %0d", $time, count, n);
      end
      checks++;
      if (sif.mem_write_enable !== drain_exp) begin
        errors++;
        $display("FAIL drain_enable @%0t: got %b, required %b", $time, sif.mem_write_enable, drain_exp);
      end else if (drain_exp) begin
        e = exp_q.pop_front();
        checks++;
        if (sif.mem_write_address !== {e[67:38], 2'b00} || sif.mem_write_select !== e[35:32] || sif.mem_write_data !== e[31:0]) begin
          errors++;
          $display("FAIL drain_entry @%0t: got a=%h s=%h d=%h, required a=%h s=%h d=%h", $time,
                   sif.mem_write_address, sif.mem_write_select, sif.mem_write_data, {e[67:38], 2'b00}, e[35:32], e[31:0]);
        end
      end
      if (sif.ram_read_enable) begin
        checks++;
        if (sif.mem_read_enable !== !hit_stall) begin
          errors++;
          $display("FAIL mem_read_enable @%0t: got %b, required %b", $time, sif.mem_read_enable, !hit_stall);
        end
        if (!stall_exp) begin
          checks++;
          if (sif.ram_read_data !== golden[sif.ram_read_address[11:2]]) begin
            errors++;
            $display("FAIL read_data @%0t addr %h: got %h, required %h", $time, sif.ram_read_address, sif.ram_read_data, golden[sif.ram_read_address[11:2]]);
          end
        end
      end
      if (sif.ram_write_enable && !stall_exp) begin
        exp_q.push_back({sif.ram_write_address, sif.ram_write_select, sif.ram_write_data});
        for (int b = 0; b < 4; b++)
          if (sif.ram_write_select[b]) golden[sif.ram_write_address[11:2]][8*b +: 8] = sif.ram_write_data[8*b +: 8];
      end
    end
  end

  task automatic drive(input logic we, input logic [31:0] wa, input logic [3:0] ws, input logic [31:0] wd,
                       input logic re, input logic [31:0] ra);
    sif.ram_write_enable  = we;
    sif.ram_write_address = wa;
    sif.ram_write_select  = ws;
    sif.ram_write_data    = wd;
    sif.ram_read_enable   = re;
    sif.ram_read_address  = ra;
  endtask

  task automatic do_cycle(input logic we, input logic [31:0] wa, input logic [3:0] ws, input logic [31:0] wd,
                          input logic re, input logic [31:0] ra, output logic stalled, output logic [31:0] rdata);
    drive(we, wa, ws, wd, re, ra);
    @(negedge clock);
    stalled = sif.stall_request;
    rdata   = sif.ram_read_data;
    @(posedge clock);
    #1;
  endtask

  task automatic drain_all();
    logic s;
    logic [31:0] d;
    int guard = 0;
    while (count != 0 && guard < 40) begin
      do_cycle(1'b0, '0, '0, '0, 1'b0, '0, s, d);
      guard++;
    end
    checks++;
    if (count != 0) begin
      errors++;
      $display("FAIL drain_timeout: count %0d, required 0", count);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 32'h100, 4'hF, 32'hDEADBEEF, 1'b1, 32'h104);
    @(posedge clock); #1;
    @(negedge clock);
    checks++;
    if (sif.mem_write_address !== '0 || sif.mem_read_address !== '0 || sif.mem_write_data !== '0 ||
        sif.mem_write_select !== '0 || sif.ram_read_data !== '0) begin
      errors++;
      $display("FAIL reset_data: wa=%h ra=%h wd=%h ws=%h rd=%h, required all 0", sif.mem_write_address,
               sif.mem_read_address, sif.mem_write_data, sif.mem_write_select, sif.ram_read_data);
    end
    checks++;
    if (count !== '0) begin
      errors++;
      $display("FAIL reset_count: got %0d, required 0", count);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic test_single_store();
    logic s;
    logic [31:0] d;
    do_cycle(1'b1, 32'h100, 4'hF, 32'h11223344, 1'b0, '0, s, d);
    drive(1'b0, '0, '0, '0, 1'b0, '0);
    @(negedge clock);
    checks++;
    if (sif.mem_write_enable !== 1'b1 || sif.mem_write_address !== 32'h100 || sif.mem_write_data !== 32'h11223344 || sif.mem_write_select !== 4'hF) begin
      errors++;
      $display("FAIL single_store: we=%b a=%h d=%h s=%h, required 1 100 11223344 f", sif.mem_write_enable,
               sif.mem_write_address, sif.mem_write_data, sif.mem_write_select);
    end
    @(posedge clock); #1;
    checks++;
    if (count !== '0) begin
      errors++;
      $display("FAIL single_store_count: got %0d, required 0", count);
    end
  endtask

  task automatic test_full_stall();
    logic s;
    logic [31:0] d;
    for (int k = 0; k < 5; k++) begin
      do_cycle(1'b1, 32'h400 + 32'(4*k), 4'hF, $urandom, 1'b1, 32'h800, s, d);
      checks++;
      if (s !== (k == 4)) begin
        errors++;
        $display("FAIL full_stall store %0d: stall %b, required %b", k, s, (k == 4));
      end
    end
    do_cycle(1'b1, 32'h410, 4'hF, 32'h55667788, 1'b0, '0, s, d);
    checks++;
    if (s !== 1'b0 || count !== 3'(DEPTH)) begin
      errors++;
      $display("FAIL full_accept: stall %b count %0d, required 0 and %0d", s, count, DEPTH);
    end
    drain_all();
  endtask

  task automatic test_read_hit();
    logic s;
    logic [31:0] d;
    int stalls = 0;
    do_cycle(1'b1, 32'h200, 4'b0001, 32'h000000BB, 1'b1, 32'h800, s, d);
    do_cycle(1'b1, 32'h200, 4'b0010, 32'h0000CC00, 1'b1, 32'h800, s, d);
    do_cycle(1'b0, '0, '0, '0, 1'b1, 32'h200, s, d);
    while (s && stalls < 10) begin
      stalls++;
      do_cycle(1'b0, '0, '0, '0, 1'b1, 32'h200, s, d);
    end
    checks++;
`ifdef STORE_BUFFER_FORWARD_EN
    if (stalls != 0 || d !== 32'hAAAACCBB) begin
      errors++;
      $display("FAIL forward_hit: stalls %0d data %h, required 0 and aaaaccbb", stalls, d);
    end
`else
    if (stalls != 2 || d !== 32'hAAAACCBB) begin
      errors++;
      $display("FAIL hit_stall: stalls %0d data %h, required 2 and aaaaccbb", stalls, d);
    end
`endif
    drain_all();
  endtask

  task automatic test_reset_full();
    logic s;
    logic [31:0] d;
    logic [31:0] old = golden[32'h300 >> 2];
    for (int k = 0; k < DEPTH; k++) do_cycle(1'b1, 32'h300 + 32'(4*k), 4'hF, $urandom, 1'b1, 32'h800, s, d);
    checks++;
    if (count !== 3'(DEPTH)) begin
      errors++;
      $display("FAIL reset_fill: count %0d, required %0d", count, DEPTH);
    end
    reset = 1'b1;
    do_cycle(1'b0, '0, '0, '0, 1'b0, '0, s, d);
    reset = 1'b0;
    checks++;
    if (count !== '0) begin
      errors++;
      $display("FAIL reset_full_count: got %0d, required 0", count);
    end
    do_cycle(1'b0, '0, '0, '0, 1'b1, 32'h300, s, d);
    checks++;
    if (s !== 1'b0 || d !== old) begin
      errors++;
      $display("FAIL reset_discard: stall %b data %h, required 0 and %h", s, d, old);
    end
  endtask

  task automatic test_wrap();
    logic s, re;
    logic [31:0] d, ra;
    int base = mem_writes;
    int tries;
    for (int i = 0; i < 10; i++) begin
      re = 1'($urandom_range(0, 1));
      ra = (i > 0 && $urandom_range(0, 1) == 1) ? 32'h600 + 32'(4 * $urandom_range(0, i - 1)) : 32'h800;
      tries = 0;
      do begin
        do_cycle(1'b1, 32'h600 + 32'(4*i), 4'hF, $urandom, re, ra, s, d);
        re = 1'b0;
        tries++;
      end while (s && tries < 20);
      checks++;
      if (s) begin
        errors++;
        $display("FAIL wrap_accept store %0d: still stalled, required accepted", i);
      end
      if ($urandom_range(0, 1) == 1) do_cycle(1'b0, '0, '0, '0, 1'b1, 32'h800, s, d);
    end
    drain_all();
    checks++;
    if (mem_writes - base != 10) begin
      errors++;
      $display("FAIL wrap_writes: got %0d, required 10", mem_writes - base);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (ram[(32'h600 >> 2) + i] !== golden[(32'h600 >> 2) + i]) begin
        errors++;
        $display("FAIL wrap_ram word %0d: got %h, required %h", i, ram[(32'h600 >> 2) + i], golden[(32'h600 >> 2) + i]);
      end
    end
  endtask

  task automatic test_random();
    logic s;
    logic [31:0] d;
    logic [3:0] sel;
    for (int i = 0; i < 300; i++) begin
      sel = 4'($urandom_range(1, 15));
      do_cycle(1'($urandom_range(0, 1)), 32'(4 * $urandom_range(0, 15)), sel, $urandom,
               ($urandom_range(0, 2) == 0), 32'(4 * $urandom_range(0, 15)), s, d);
    end
    drain_all();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (ram[i] !== golden[i]) begin
        errors++;
        $display("FAIL random_ram word %0d: got %h, required %h", i, ram[i], golden[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i]    = $urandom;
      golden[i] = ram[i];
    end
    ram[32'h200 >> 2]    = 32'hAAAAAAAA;
    golden[32'h200 >> 2] = 32'hAAAAAAAA;
    drive(1'b0, '0, '0, '0, 1'b0, '0);
    test_reset();
    test_single_store();
    test_full_stall();
    test_read_hit();
    test_reset_full();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end
endmodule
